// File: rtl/fmap_stream_source_if.sv
// ---------------------------------------------------------------------------
// fmap_stream_source_if
//   Bundles the frame-SRAM read port, the line-buffer pixel stream and the
//   frame control/status strobes of fmap_stream_source.
//
//   Signals:
//     start      frame start request (sampled only while idle)
//     stall      pause read issue while high
//     mem_ren    frame SRAM read enable
//     mem_addr   frame SRAM read address, row*NW+col
//     mem_rdata  SRAM read data, valid one cycle after mem_ren
//     valid      pixel strobe to the line buffer
//     D          packed pixel word (NFMAPS channels of BITWIDTH bits)
//     busy       frame in progress
//     done       one-cycle completion pulse
//
//   master: the stream source.  slave: the environment (controller, SRAM,
//   line buffer) around it.
// ---------------------------------------------------------------------------
interface fmap_stream_source_if #(
    parameter int BITWIDTH = 8,
    parameter int NFMAPS   = 3,
    parameter int AW       = 10
);
    logic                         start;
    logic                         stall;
    logic                         mem_ren;
    logic [AW-1:0]                mem_addr;
    logic [NFMAPS*BITWIDTH-1:0]   mem_rdata;
    logic                         valid;
    logic [NFMAPS*BITWIDTH-1:0]   D;
    logic                         busy;
    logic                         done;

    modport master (
        input  start, stall, mem_rdata,
        output mem_ren, mem_addr, valid, D, busy, done
    );

    modport slave (
        output start, stall, mem_rdata,
        input  mem_ren, mem_addr, valid, D, busy, done
    );
endinterface

// File: rtl/fmap_stream_source.sv
// ---------------------------------------------------------------------------
// fmap_stream_source
//   Frame-side producer for the sliding-window line buffer. Reads a stored
//   multi-channel feature map from a frame SRAM in raster order (one packed
//   pixel per cycle), inserts ROW_GAP idle cycles between rows, appends PAD
//   all-zero rows for bottom padding and pulses done when the frame is out.
//
//   Ports:
//     clk    clock
//     rstn   synchronous active-low reset
//     bus    fmap_stream_source_if.master:
//              start/stall in, mem_ren/mem_addr out, mem_rdata in,
//              valid/D out, busy/done out
//
//   Timing: a read (or zero-pixel dummy) issued in cycle t is presented as
//   valid=1 in cycle t+1; D is the SRAM output for reads, zero for dummies.
// ---------------------------------------------------------------------------
module fmap_stream_source #(
    parameter int BITWIDTH = 8,
    parameter int NFMAPS   = 3,
    parameter int NW       = 32,
    parameter int NH       = 32,
    parameter int PAD      = 1,
    parameter int ROW_GAP  = 2,
    parameter int AW       = $clog2(NW*NH)
) (
    input  logic                 clk,
    input  logic                 rstn,
    fmap_stream_source_if.master bus
);

    localparam int CW = (NW > 1)      ? $clog2(NW)      : 1;
    localparam int RW = (NH > 1)      ? $clog2(NH)      : 1;
    localparam int PW = (PAD > 1)     ? $clog2(PAD)     : 1;
    localparam int GW = (ROW_GAP > 1) ? $clog2(ROW_GAP) : 1;

    localparam logic [CW-1:0] COL_LAST = CW'(NW - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(NH - 1);
    localparam logic [PW-1:0] PAD_LAST = PW'(PAD - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(ROW_GAP - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ROW,
        S_GAP,
        S_PADROW,
        S_FLUSH
    } state_t;

    state_t        r_state,         w_state_nxt;
    logic [CW-1:0] r_col,           w_col_nxt;
    logic [RW-1:0] r_row,           w_row_nxt;
    logic [PW-1:0] r_pad_row,       w_pad_row_nxt;
    logic [GW-1:0] r_gap_cnt,       w_gap_cnt_nxt;
    logic          r_gap_after_pad, w_gap_after_pad_nxt;
    logic          r_rd_issued;
    logic          r_dummy_issued;
    logic          r_done;
    logic          w_mem_ren;
    logic          w_dummy;
    logic          w_last_frame_row;
    logic          w_last_pad_row;

    // The very last row of the frame goes straight to FLUSH: a trailing gap
    // would only delay done, since nothing follows it.
    assign w_last_frame_row = (r_row == ROW_LAST) && (PAD == 0);
    assign w_last_pad_row   = (r_pad_row == PAD_LAST);

    // -----------------------------------------------------------------------
    // Next-state / issue logic
    // -----------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal gets its default before the case so no path
        // leaves one unassigned, which would infer a latch.
        w_state_nxt         = r_state;
        w_col_nxt           = r_col;
        w_row_nxt           = r_row;
        w_pad_row_nxt       = r_pad_row;
        w_gap_cnt_nxt       = r_gap_cnt;
        w_gap_after_pad_nxt = r_gap_after_pad;
        w_mem_ren           = 1'b0;
        w_dummy             = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_state_nxt         = S_ROW;
                    w_col_nxt           = '0;
                    w_row_nxt           = '0;
                    w_pad_row_nxt       = '0;
                    w_gap_cnt_nxt       = '0;
                    w_gap_after_pad_nxt = 1'b0;
                end
            end

            S_ROW: begin
                if (!bus.stall) begin
                    w_mem_ren = 1'b1;
                    if (r_col == COL_LAST) begin
                        w_col_nxt = '0;
                        if (ROW_GAP > 0 && !w_last_frame_row) begin
                            w_state_nxt         = S_GAP;
                            w_gap_cnt_nxt       = '0;
                            w_gap_after_pad_nxt = 1'b0;
                        end else if (r_row != ROW_LAST) begin
                            w_state_nxt = S_ROW;
                            w_row_nxt   = r_row + RW'(1);
                        end else if (PAD > 0) begin
                            w_state_nxt   = S_PADROW;
                            w_row_nxt     = '0;
                            w_pad_row_nxt = '0;
                        end else begin
                            w_state_nxt = S_FLUSH;
                            w_row_nxt   = '0;
                        end
                    end else begin
                        w_col_nxt = r_col + CW'(1);
                    end
                end
            end

            // The gap counts wall-clock cycles; stall does not stretch it.
            S_GAP: begin
                if (r_gap_cnt == GAP_LAST) begin
                    w_gap_cnt_nxt = '0;
                    if (r_gap_after_pad) begin
                        if (!w_last_pad_row) begin
                            w_state_nxt   = S_PADROW;
                            w_pad_row_nxt = r_pad_row + PW'(1);
                        end else begin
                            w_state_nxt   = S_FLUSH;
                            w_pad_row_nxt = '0;
                        end
                    end else if (r_row != ROW_LAST) begin
                        w_state_nxt = S_ROW;
                        w_row_nxt   = r_row + RW'(1);
                    end else if (PAD > 0) begin
                        w_state_nxt   = S_PADROW;
                        w_row_nxt     = '0;
                        w_pad_row_nxt = '0;
                    end else begin
                        w_state_nxt = S_FLUSH;
                        w_row_nxt   = '0;
                    end
                end else begin
                    w_gap_cnt_nxt = r_gap_cnt + GW'(1);
                end
            end

            S_PADROW: begin
                if (!bus.stall) begin
                    w_dummy = 1'b1;
                    if (r_col == COL_LAST) begin
                        w_col_nxt = '0;
                        if (ROW_GAP > 0 && !w_last_pad_row) begin
                            w_state_nxt         = S_GAP;
                            w_gap_cnt_nxt       = '0;
                            w_gap_after_pad_nxt = 1'b1;
                        end else if (!w_last_pad_row) begin
                            w_state_nxt   = S_PADROW;
                            w_pad_row_nxt = r_pad_row + PW'(1);
                        end else begin
                            w_state_nxt   = S_FLUSH;
                            w_pad_row_nxt = '0;
                        end
                    end else begin
                        w_col_nxt = r_col + CW'(1);
                    end
                end
            end

            // One cycle for the last issued pixel to reach the output.
            S_FLUSH: w_state_nxt = S_IDLE;

            default: w_state_nxt = S_IDLE;
        endcase
    end

    // -----------------------------------------------------------------------
    // State and output pipeline registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: reset is sampled on the clock edge only (synchronous), and all
        // state uses non-blocking assignments so every flop sees pre-edge values.
        if (!rstn) begin
            r_state         <= S_IDLE;
            r_col           <= '0;
            r_row           <= '0;
            r_pad_row       <= '0;
            r_gap_cnt       <= '0;
            r_gap_after_pad <= 1'b0;
            r_rd_issued     <= 1'b0;
            r_dummy_issued  <= 1'b0;
            r_done          <= 1'b0;
        end else begin
            r_state         <= w_state_nxt;
            r_col           <= w_col_nxt;
            r_row           <= w_row_nxt;
            r_pad_row       <= w_pad_row_nxt;
            r_gap_cnt       <= w_gap_cnt_nxt;
            r_gap_after_pad <= w_gap_after_pad_nxt;
            r_rd_issued     <= w_mem_ren;
            r_dummy_issued  <= w_dummy;
            // done lands in the IDLE cycle after FLUSH, when busy drops.
            r_done          <= (r_state == S_FLUSH);
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign bus.mem_ren  = w_mem_ren;
    assign bus.mem_addr = AW'(r_row) * AW'(NW) + AW'(r_col);
    assign bus.valid    = r_rd_issued | r_dummy_issued;
    // SRAM data arrives exactly one cycle after the read, aligned with valid;
    // dummy (pad) pixels and idle cycles present zero.
    assign bus.D        = r_rd_issued ? bus.mem_rdata : {(NFMAPS*BITWIDTH){1'b0}};
    assign bus.busy     = (r_state != S_IDLE);
    assign bus.done     = r_done;

endmodule

// File: tb/tb_fmap_stream_source.sv
// ---------------------------------------------------------------------------
// tb_fmap_stream_source
//   Bench for fmap_stream_source. Three instances: the main configuration
//   (NW=4, NH=3, PAD=1, ROW_GAP=2), a back-to-back one (ROW_GAP=0, PAD=0)
//   and a double-pad one (PAD=2). Expected behaviour comes from an
//   arithmetic frame-timing model and a raster-order stream scoreboard.
// ---------------------------------------------------------------------------
module tb_fmap_stream_source;

    localparam int BW   = 8;
    localparam int NF   = 3;
    localparam int DW   = NF * BW;
    localparam int NW   = 4;
    localparam int NH   = 3;
    localparam int AW   = 4;
    localparam int NREC = 34;
    localparam int MAXR = 200;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    fmap_stream_source_if #(.BITWIDTH(BW), .NFMAPS(NF), .AW(AW)) m_if ();
    fmap_stream_source_if #(.BITWIDTH(BW), .NFMAPS(NF), .AW(AW)) a_if ();
    fmap_stream_source_if #(.BITWIDTH(BW), .NFMAPS(NF), .AW(AW)) b_if ();

    fmap_stream_source #(.BITWIDTH(BW), .NFMAPS(NF), .NW(NW), .NH(NH),
                         .PAD(1), .ROW_GAP(2), .AW(AW))
        u_main (.clk(clk), .rstn(rstn), .bus(m_if));
    fmap_stream_source #(.BITWIDTH(BW), .NFMAPS(NF), .NW(NW), .NH(NH),
                         .PAD(0), .ROW_GAP(0), .AW(AW))
        u_nogap (.clk(clk), .rstn(rstn), .bus(a_if));
    fmap_stream_source #(.BITWIDTH(BW), .NFMAPS(NF), .NW(NW), .NH(NH),
                         .PAD(2), .ROW_GAP(2), .AW(AW))
        u_pad2 (.clk(clk), .rstn(rstn), .bus(b_if));

    // Default frame contents: mem[a] = a+1 in every channel.
    function automatic logic [DW-1:0] pix(input int a);
        logic [BW-1:0] b;
        b = BW'(a + 1);
        return {NF{b}};
    endfunction

    // Frame SRAMs: data one cycle after the read enable.
    logic [DW-1:0] mem_main [16];
    always @(posedge clk) if (m_if.mem_ren) m_if.mem_rdata <= mem_main[m_if.mem_addr];
    always @(posedge clk) if (a_if.mem_ren) a_if.mem_rdata <= pix(int'(a_if.mem_addr));
    always @(posedge clk) if (b_if.mem_ren) b_if.mem_rdata <= pix(int'(b_if.mem_addr));

    // -----------------------------------------------------------------------
    // Checking
    // -----------------------------------------------------------------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    typedef struct {
        logic          valid;
        logic [DW-1:0] d;
        logic          busy;
        logic          done;
        logic          ren;
        int            addr;
    } exp_t;

    typedef struct {
        bit   start;
        bit   stall;
        exp_t e [3];
    } vec_t;

    // Frame timing for a start sampled at the end of record 0 and no stall:
    // row i (frame rows then pad rows) issues its pixels in records
    // 1 + i*(nw+g) .. +nw-1, each pixel shows one record later, done comes
    // one record after the last pixel.
    function automatic exp_t model_at(int j, int nw, int nh, int pad, int g);
        exp_t r;
        int rows, period, last, k, i, c;
        rows   = nh + pad;
        period = nw + g;
        last   = 1 + (rows - 1) * period + (nw - 1);
        r.valid = 1'b0;
        r.d     = '0;
        r.ren   = 1'b0;
        r.addr  = 0;
        r.busy  = (j >= 1 && j <= last + 1);
        r.done  = (j == last + 2);
        if (j >= 1 && j <= last) begin
            k = j - 1; i = k / period; c = k % period;
            if (c < nw && i < nh) begin
                r.ren  = 1'b1;
                r.addr = i * nw + c;
            end
        end
        if (j >= 2 && j <= last + 1) begin
            k = j - 2; i = k / period; c = k % period;
            if (c < nw) begin
                r.valid = 1'b1;
                r.d     = (i < nh) ? pix(i * nw + c) : '0;
            end
        end
        return r;
    endfunction

    function automatic exp_t get_obs(int c);
        exp_t o;
        case (c)
            0: begin o.valid = m_if.valid; o.d = m_if.D; o.busy = m_if.busy;
                     o.done = m_if.done; o.ren = m_if.mem_ren; o.addr = int'(m_if.mem_addr); end
            1: begin o.valid = a_if.valid; o.d = a_if.D; o.busy = a_if.busy;
                     o.done = a_if.done; o.ren = a_if.mem_ren; o.addr = int'(a_if.mem_addr); end
            default: begin o.valid = b_if.valid; o.d = b_if.D; o.busy = b_if.busy;
                     o.done = b_if.done; o.ren = b_if.mem_ren; o.addr = int'(b_if.mem_addr); end
        endcase
        return o;
    endfunction

    // -----------------------------------------------------------------------
    // Main-instance frame runner and stream scoreboard
    // -----------------------------------------------------------------------
    bit            stall_pat  [MAXR];
    logic          obs_valid  [MAXR];
    logic [DW-1:0] obs_d      [MAXR];
    logic          obs_ren    [MAXR];
    int            obs_addr   [MAXR];
    logic          obs_busy   [MAXR];
    logic          obs_done   [MAXR];

    // Start in record 0, drive stall_pat, stop one record after done.
    task automatic run_main(output int done_rec);
        done_rec = -1;
        for (int j = 0; j < MAXR; j++) begin
            @(posedge clk); #1;
            m_if.start = (j == 0);
            m_if.stall = stall_pat[j];
            @(negedge clk);
            obs_valid[j] = m_if.valid;
            obs_d[j]     = m_if.D;
            obs_ren[j]   = m_if.mem_ren;
            obs_addr[j]  = int'(m_if.mem_addr);
            obs_busy[j]  = m_if.busy;
            obs_done[j]  = m_if.done;
            if (m_if.done === 1'b1 && done_rec < 0) done_rec = j;
            if (done_rec >= 0 && j >= done_rec + 1) break;
        end
        m_if.start = 1'b0;
        m_if.stall = 1'b0;
    endtask

    task automatic check_stream(input string name, input int dr);
        logic [DW-1:0] exp_q [$];
        int nvalid, bad_d, nren, bad_addr, ren_stalled, late;
        check({name, " done seen"}, (dr >= 2), 1);
        if (dr < 2) return;
        for (int a = 0; a < NW * NH; a++) exp_q.push_back(mem_main[a]);
        for (int p = 0; p < NW; p++) exp_q.push_back('0);
        nvalid = 0; bad_d = 0; nren = 0; bad_addr = 0; ren_stalled = 0; late = 0;
        for (int j = 0; j <= dr + 1; j++) begin
            if (obs_valid[j] === 1'b1) begin
                if (nvalid >= exp_q.size() || obs_d[j] !== exp_q[nvalid]) bad_d++;
                if (j >= dr) late++;
                nvalid++;
            end
            if (obs_ren[j] === 1'b1) begin
                if (obs_addr[j] != nren) bad_addr++;
                if (stall_pat[j]) ren_stalled++;
                nren++;
            end
        end
        check({name, " valid count"},      nvalid, exp_q.size());
        check({name, " data mismatches"},  bad_d, 0);
        check({name, " read count"},       nren, NW * NH);
        check({name, " addr order errs"},  bad_addr, 0);
        check({name, " reads while stall"}, ren_stalled, 0);
        check({name, " valid after done"}, late, 0);
        check({name, " valid before done"}, obs_valid[dr - 1], 1);
        check({name, " busy before done"}, obs_busy[dr - 1], 1);
        check({name, " busy with done"},   obs_busy[dr], 0);
        check({name, " done one pulse"},   obs_done[dr + 1], 0);
    endtask

    // -----------------------------------------------------------------------
    // Test sequence
    // -----------------------------------------------------------------------
    vec_t tbl [NREC];

    initial begin
        int   dr, nv, nd;
        exp_t o;

        for (int j = 0; j < NREC; j++) begin
            tbl[j].start = (j == 0 || j == 5 || j == 11); // later starts arrive while busy
            tbl[j].stall = 1'b0;
            tbl[j].e[0]  = model_at(j, NW, NH, 1, 2);
            tbl[j].e[1]  = model_at(j, NW, NH, 0, 0);
            tbl[j].e[2]  = model_at(j, NW, NH, 2, 2);
        end
        for (int a = 0; a < 16; a++) mem_main[a] = pix(a);

        m_if.start = 1'b0; m_if.stall = 1'b0;
        a_if.start = 1'b0; a_if.stall = 1'b0;
        b_if.start = 1'b0; b_if.stall = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1 rstn = 1'b1;
        @(negedge clk);
        check("reset valid", m_if.valid, 0);
        check("reset D",     m_if.D, 0);
        check("reset busy",  m_if.busy, 0);
        check("reset done",  m_if.done, 0);
        check("reset ren",   m_if.mem_ren, 0);
        check("reset addr",  m_if.mem_addr, 0);

        // Table: basic frame, latency, gaps, corner configs, start while busy
        for (int j = 0; j < NREC; j++) begin
            @(posedge clk); #1;
            m_if.start = tbl[j].start; m_if.stall = tbl[j].stall;
            a_if.start = tbl[j].start; a_if.stall = tbl[j].stall;
            b_if.start = tbl[j].start; b_if.stall = tbl[j].stall;
            @(negedge clk);
            for (int c = 0; c < 3; c++) begin
                o = get_obs(c);
                check($sformatf("tbl cfg%0d rec%0d valid", c, j), o.valid, tbl[j].e[c].valid);
                check($sformatf("tbl cfg%0d rec%0d D", c, j),     o.d,     tbl[j].e[c].d);
                check($sformatf("tbl cfg%0d rec%0d busy", c, j),  o.busy,  tbl[j].e[c].busy);
                check($sformatf("tbl cfg%0d rec%0d done", c, j),  o.done,  tbl[j].e[c].done);
                check($sformatf("tbl cfg%0d rec%0d ren", c, j),   o.ren,   tbl[j].e[c].ren);
                if (tbl[j].e[c].ren)
                    check($sformatf("tbl cfg%0d rec%0d addr", c, j), o.addr, tbl[j].e[c].addr);
            end
        end
        m_if.start = 1'b0; a_if.start = 1'b0; b_if.start = 1'b0;

        // Stall for 3 cycles right after addr 5 (row 1, col 1) is issued
        for (int j = 0; j < MAXR; j++) stall_pat[j] = (j >= 9 && j <= 11);
        run_main(dr);
        check("stall addr5 issued", obs_ren[8], 1);
        check("stall addr5 value",  obs_addr[8], 5);
        check("stall pixel6 valid", obs_valid[9], 1);
        check("stall pixel6 D",     obs_d[9], pix(5));
        nv = 0;
        for (int j = 10; j <= 12; j++) if (obs_valid[j] === 1'b1) nv++;
        check("stall idle valids",  nv, 0);
        check("stall resume ren",   obs_ren[12], 1);
        check("stall resume addr",  obs_addr[12], 6);
        check("stall pixel7 D",     obs_d[13], pix(6));
        check_stream("stall", dr);

        // Random stall and random frame contents
        for (int r = 0; r < 4; r++) begin
            for (int a = 0; a < 16; a++) mem_main[a] = DW'($urandom);
            for (int j = 0; j < MAXR; j++) stall_pat[j] = (j > 0) && ($urandom_range(0, 2) == 0);
            run_main(dr);
            check_stream($sformatf("rand%0d", r), dr);
        end

        // Reset during row 1: abort, no done, then replay from addr 0
        for (int a = 0; a < 16; a++) mem_main[a] = pix(a);
        for (int j = 0; j < 10; j++) begin
            @(posedge clk); #1;
            m_if.start = (j == 0);
            rstn       = (j != 9);
            @(negedge clk);
            if (j == 8) check("abort busy before reset", m_if.busy, 1);
        end
        @(posedge clk); #1;
        rstn = 1'b1;
        @(negedge clk);
        check("abort valid", m_if.valid, 0);
        check("abort busy",  m_if.busy, 0);
        check("abort ren",   m_if.mem_ren, 0);
        check("abort D",     m_if.D, 0);
        check("abort addr",  m_if.mem_addr, 0);
        nv = 0; nd = 0;
        for (int j = 0; j < 30; j++) begin
            @(negedge clk);
            if (m_if.valid === 1'b1) nv++;
            if (m_if.done === 1'b1) nd++;
        end
        check("abort no valid", nv, 0);
        check("abort no done",  nd, 0);

        for (int j = 0; j < MAXR; j++) stall_pat[j] = 1'b0;
        run_main(dr);
        check("replay first ren",  obs_ren[1], 1);
        check("replay first addr", obs_addr[1], 0);
        check("replay first D",    obs_d[2], pix(0));
        check_stream("replay", dr);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
